// File: rtl/ysyx_23060191_if_id_queue.sv
// IF->ID instruction queue: circular FIFO of {pc, inst}, 1-cycle latency, in_ready = !full (no full pass-through).
// Optional YSYX_23060191_IFQ_BYPASS_EN: an empty queue forwards the input combinationally to decode.
module ysyx_23060191_if_id_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_inst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            full_q;
  logic            nempty_q;
  logic            enq;
  logic            deq;
  logic            bypass;

`ifdef YSYX_23060191_IFQ_BYPASS_EN
  assign bypass = !nempty_q && in_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed instruction that decode takes right away never touches storage.
  assign enq = in_valid && !full_q && !flush && !(bypass && out_ready);
  assign deq = nempty_q && out_ready && !flush;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({enq, deq})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // full/non-empty are kept as flops so in_ready/out_valid come straight from registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      nempty_q <= 1'b0;
    end else if (flush) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      nempty_q <= 1'b0;
    end else begin
      if (enq) wptr <= wptr + AW'(1);
      if (deq) rptr <= rptr + AW'(1);
      cnt_q    <= cnt_d;
      full_q   <= (cnt_d == CW'(DEPTH));
      nempty_q <= (cnt_d != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && enq) begin
      mem[wptr] <= '{pc: in_pc, inst: in_inst};
    end
  end

  assign head     = mem[rptr];
  assign in_ready = !full_q;
  assign count    = cnt_q;

`ifdef YSYX_23060191_IFQ_BYPASS_EN
  assign out_valid = nempty_q || bypass;
  assign out_pc    = bypass ? in_pc   : head.pc;
  assign out_inst  = bypass ? in_inst : head.inst;
`else
  assign out_valid = nempty_q;
  assign out_pc    = head.pc;
  assign out_inst  = head.inst;
`endif

endmodule

// File: tb/tb_ysyx_23060191_if_id_queue.sv
// Scoreboard bench for the IF->ID queue: stimulus pushes expected {pc, inst}, a negedge monitor pops on each handshake.
module tb_ysyx_23060191_if_id_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

`ifdef YSYX_23060191_IFQ_BYPASS_EN
  localparam logic [2:0] STREAM_CNT = 3'd0;
  localparam logic [2:0] BYP_CNT    = 3'd0;
`else
  localparam logic [2:0] STREAM_CNT = 3'd1;
  localparam logic [2:0] BYP_CNT    = 3'd1;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_inst;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_inst;
  logic [2:0]      count;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_q [$];

  ysyx_23060191_if_id_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] inst, input bit expect_it);
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
    if (expect_it) exp_q.push_back({pc, inst});
  endtask

  // Monitor: every handshake that the DUT will honour must match the next expected entry.
  always @(negedge clk) begin
    if (rst === 1'b0 && flush === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", {out_pc, out_inst}, 64'h0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("out_pc", out_pc, e[63:32]);
        check("out_inst", out_inst, e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0;
    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_count", count, 0);
    rst = 1'b0;
    step();
    check("post_rst_count", count, 0);
    check("post_rst_out_valid", out_valid, 0);

    // Fill to full with decode stalled.
    for (int i = 0; i < 4; i++) begin
      drive(32'h8000_0000 + 32'(4 * i), 32'h1000_0000 + 32'(i), 1'b1);
      step();
    end
    check("full_count", count, 4);
    check("full_in_ready", in_ready, 0);
    check("full_out_valid", out_valid, 1);
    drive(32'h8000_0010, 32'h1000_0004, 1'b0);
    step();
    check("fifth_refused_count", count, 4);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      step();
      check("drain_count", count, 3'(i));
    end
    check("drained_out_valid", out_valid, 0);
    out_ready = 1'b0;

    // Streaming through the pointer wrap.
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(32'h9000_0000 + 32'(4 * i), 32'h2000_0000 + 32'(i), 1'b1);
      step();
      check("stream_count", count, STREAM_CNT);
    end
    in_valid = 1'b0;
    step();
    check("stream_end_count", count, 0);
    out_ready = 1'b0;

    // Full with simultaneous dequeue: head leaves, input refused.
    for (int i = 0; i < 4; i++) begin
      drive(32'hA000_0000 + 32'(4 * i), 32'h3000_0000 + 32'(i), 1'b1);
      step();
    end
    check("full2_count", count, 4);
    drive(32'hA000_0010, 32'h3000_0004, 1'b0);
    out_ready = 1'b1;
    step();
    check("full_deq_count", count, 3);
    check("full_deq_in_ready", in_ready, 1);
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Flush at count 3 together with an input that must vanish.
    flush = 1'b1;
    drive(32'hB000_0000, 32'hDEAD_BEEF, 1'b0);
    out_ready = 1'b1;
    exp_q.delete();
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("flush_count", count, 0);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    step();
    check("flush_stays_empty", out_valid, 0);

    // Empty queue with decode ready: same-cycle with bypass, one cycle later without.
    out_ready = 1'b1;
    drive(32'hC000_0000, 32'h0010_0093, 1'b1);
    #1;
`ifdef YSYX_23060191_IFQ_BYPASS_EN
    check("byp_out_valid", out_valid, 1);
    check("byp_out_inst", out_inst, 32'h0010_0093);
`else
    check("nobyp_out_valid", out_valid, 0);
`endif
    step();
    in_valid = 1'b0;
    check("byp_count", count, BYP_CNT);
    step();
    check("byp_end_count", count, 0);
    out_ready = 1'b0;

    // Reset in the middle of operation.
    for (int i = 0; i < 2; i++) begin
      drive(32'hD000_0000 + 32'(4 * i), 32'h4000_0000 + 32'(i), 1'b1);
      step();
    end
    check("mid_count", count, 2);
    in_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
    check("midrst_count", count, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);

    // A fresh entry after reset still flows.
    out_ready = 1'b1;
    drive(32'hE000_0000, 32'h5000_0000, 1'b1);
    step();
    in_valid = 1'b0;
    step(); step();
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
